// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling feeding a small byte FIFO.
// Frame errors and dropped bytes are reported as single-cycle pulses.
module uart_rx_fifo #(
    parameter int CLK_FREQUENCY = 50000000,
    parameter int BAUD_RATE     = 115200,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_error,
    output logic       overflow,
    output logic       busy
);

    localparam int DIV   = (CLK_FREQUENCY + 8 * BAUD_RATE) / (16 * BAUD_RATE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam int AW    = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t           r_state;
    logic             r_sync1;
    logic             r_sync2;
    logic [1:0]       r_prime;
    logic [DIV_W-1:0] r_div_cnt;
    logic [3:0]       r_tick_cnt;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic             r_wait_high;
    logic             r_frame_error;
    logic             r_overflow;
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;

    logic w_rxs;
    logic w_tick;
    logic w_start;
    logic w_stop_sample;
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_rxs         = r_sync2;
    assign w_tick        = (r_div_cnt == DIV_LAST);
    assign w_start       = (r_state == S_IDLE) && !r_wait_high && !w_rxs;
    assign w_stop_sample = (r_state == S_STOP) && w_tick && (r_tick_cnt == 4'd15);
    assign w_empty       = (r_wr_ptr == r_rd_ptr);
    assign w_full        = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                           (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop         = !w_empty && rx_ready;
    assign w_push        = w_stop_sample && w_rxs && (!w_full || w_pop);
    assign w_drop        = w_stop_sample && w_rxs && w_full && !w_pop;

    assign rx_data     = r_mem[r_rd_ptr[AW-1:0]];
    assign rx_valid    = !w_empty;
    assign frame_error = r_frame_error;
    assign overflow    = r_overflow;
    assign busy        = (r_state != S_IDLE);

    // Two-flop synchronizer; r_prime marks when rxs reflects the real pin after reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prime <= 2'b00;
        end else begin
            r_sync1 <= uart_rx;
            r_sync2 <= r_sync1;
            r_prime <= {r_prime[0], 1'b1};
        end
    end

    // Oversample divider; phase restarts on a detected start edge to centre samples.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_div_cnt <= {DIV_W{1'b0}};
        end else if (w_start || w_tick) begin
            r_div_cnt <= {DIV_W{1'b0}};
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    // Receiver FSM; r_wait_high blocks a new start after reset or a low stop bit.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_tick_cnt    <= 4'd0;
            r_bit_cnt     <= 3'd0;
            r_shift       <= 8'h00;
            r_wait_high   <= 1'b1;
            r_frame_error <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_frame_error <= 1'b0;
            r_overflow    <= w_drop;
            case (r_state)
                S_IDLE: begin
                    if (r_wait_high) begin
                        if (w_rxs && r_prime[1]) begin
                            r_wait_high <= 1'b0;
                        end
                    end else if (!w_rxs) begin
                        r_state    <= S_START;
                        r_tick_cnt <= 4'd0;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        if (r_tick_cnt == 4'd7) begin
                            r_tick_cnt <= 4'd0;
                            r_bit_cnt  <= 3'd0;
                            r_state    <= w_rxs ? S_IDLE : S_DATA;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 4'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        r_tick_cnt <= r_tick_cnt + 4'd1;
                        if (r_tick_cnt == 4'd15) begin
                            r_shift   <= {w_rxs, r_shift[7:1]};
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_state <= S_STOP;
                            end
                        end
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        r_tick_cnt <= r_tick_cnt + 4'd1;
                        if (r_tick_cnt == 4'd15) begin
                            r_state <= S_IDLE;
                            if (!w_rxs) begin
                                r_frame_error <= 1'b1;
                                r_wait_high   <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // FIFO storage and pointers; push and pop may both happen in one cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= {(AW+1){1'b0}};
            r_rd_ptr <= {(AW+1){1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= r_shift;
                r_wr_ptr                <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter CLK_FREQUENCY, default 50000000, system clock rate in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, serial bit rate in baud.
REQ-003 Parameter FIFO_DEPTH, default 4, received-byte buffer entries; SHALL be a power of two, at least 2.
REQ-004 clk  input  1  single system clock; all logic SHALL be on its rising edge.
REQ-005 reset_n  input  1  reset; synchronous, active-low.
REQ-006 uart_rx  input  1  asynchronous serial line from the board pin; idles high; 8N1 framing.
REQ-007 rx_data  output  8  byte at the FIFO head; valid only while rx_valid=1.
REQ-008 rx_valid  output  1  FIFO not empty.
REQ-009 rx_ready  input  1  consumer accepts the head byte when rx_valid and rx_ready are both 1 on a clock edge.
REQ-010 frame_error  output  1  one-cycle pulse when a frame's stop bit samples low.
REQ-011 overflow  output  1  one-cycle pulse when a good frame arrives while the FIFO is full.
REQ-012 busy  output  1  high while the receiver FSM is not in IDLE.

Function
REQ-013 uart_rx SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value rxs.
REQ-014 Oversample tick: a counter SHALL pulse once every DIV = round(CLK_FREQUENCY / (16*BAUD_RATE)) clocks (27 at defaults); one bit = 16 ticks.
REQ-015 FSM states: IDLE, START, DATA, STOP.
REQ-016 IDLE -> START on rxs=0; the tick phase SHALL restart at that cycle so sampling is centred.
REQ-017 START: at tick 8 sample rxs; 1 -> IDLE (glitch, no output); 0 -> DATA, tick count reset.
REQ-018 DATA: every 16 ticks sample one bit, LSB first, into an 8-bit shift register; after bit 7 -> STOP.
REQ-019 STOP: after 16 ticks sample rxs; 1 -> push byte if FIFO not full, else pulse overflow and drop the byte; 0 -> pulse frame_error, no push; both cases -> IDLE.
REQ-020 After STOP with rxs still 0 (break), IDLE SHALL NOT restart until rxs has been seen at 1 for at least one cycle.
REQ-021 Push-to-rx_valid latency: rx_valid SHALL rise on the clock edge following the stop-bit sample cycle.
REQ-022 FIFO: read/write pointers one bit wider than log2(FIFO_DEPTH); empty when equal; full when the MSBs differ and all other bits are equal; pointers wrap modulo 2*FIFO_DEPTH.
REQ-023 A simultaneous push and pop SHALL both take effect in the same cycle, including when full (pop frees the slot, push succeeds, no overflow) and when empty with one entry (count unchanged).
REQ-024 rx_data SHALL be combinational from the head entry; it SHALL NOT change while rx_valid=1 and rx_ready=0.
REQ-025 Popping when empty SHALL have no effect.
REQ-026 frame_error and overflow SHALL never be high in the same cycle and are low otherwise.

Reset
REQ-027 While reset_n=0 at a clock edge: FSM -> IDLE, FIFO pointers -> 0, tick/bit counters -> 0, synchronizer flops -> 1.
REQ-028 Reset outputs: rx_valid=0, frame_error=0, overflow=0, busy=0; rx_data undefined-but-stable (0 permitted).
REQ-029 Reset mid-frame SHALL abandon the frame; the remaining bits SHALL NOT be decoded as a new frame until the line is seen high after reset.

Verification
REQ-030 Defaults, rx_ready=1, send 0xA5 at 432 clocks/bit -> one rx_valid cycle with rx_data=0xA5, frame_error=0, overflow=0.
REQ-031 rx_ready=0, send 0x01,0x02,0x03,0x04,0x55 -> 4 bytes held, overflow pulses once at the fifth stop bit; then draining with rx_ready=1 yields 0x01..0x04 in order, then rx_valid=0.
REQ-032 Send 0x3C with the stop bit driven low -> frame_error one pulse, rx_valid stays 0, next good frame 0x7E received correctly.
REQ-033 150-clock low glitch on idle line -> busy high for about 216 clocks, then IDLE; no rx_valid, no frame_error.
REQ-034 FIFO full with rx_ready asserted in the exact stop-sample cycle of a new frame -> no overflow; count remains 4; new byte last in order.
REQ-035 Assert reset_n=0 for 2 clocks during bit 3 of a frame, release -> all outputs 0, the partial frame is discarded, and a following 0xC3 is received correctly.
